// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider width, divider FSM states, divide-by-zero result.
package alu_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic [DIV_W-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  // Two's-complement negation, used for operand magnitudes and result sign fix-up.
  function automatic logic [DIV_W-1:0] twos_neg(input logic [DIV_W-1:0] x);
    return ~x + {{(DIV_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sub_32.sv
// 32-bit subtractor: diff = a - b, cout = 1 when no borrow occurred (a >= b unsigned).
module sub_32
  import alu_pkg::*;
(
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  output logic [DIV_W-1:0] diff,
  output logic             cout
);

  // a + ~b + 1; the carry out of the top bit is the inverted borrow.
  assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + {{DIV_W{1'b0}}, 1'b1};

endmodule

// File: rtl/div_32_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient on LO (quotient), remainder on HI (remainder).
//
// state | meaning
// IDLE  | waiting for start
// CALC  | 32 shift-subtract iterations, cnt 0..31
// FIX   | two cycles: sign fix-up and result write on the first, handoff on the second
// DONE  | done pulse; results valid; a new start is accepted here
module div_32_seq
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [DIV_W-1:0] A,
  input  logic [DIV_W-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t state, state_next;

  logic [4:0]       cnt;
  logic [DIV_W-1:0] rem_q;
  logic [DIV_W-1:0] quo_q;
  logic [DIV_W-1:0] dsr_q;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             b_zero;
  logic [DIV_W-1:0] rem_sh;
  logic             sh_out;
  logic [DIV_W-1:0] trial;
  logic             no_borrow;
  logic             take;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign b_zero = (B == '0);

  // {R, Q} shifted left one bit; the bit leaving R[31] is kept so divisors
  // at or above 2^31 still work with a 32-bit subtractor.
  assign sh_out = rem_q[DIV_W-1];
  assign rem_sh = {rem_q[DIV_W-2:0], quo_q[DIV_W-1]};
  assign take   = sh_out | no_borrow;

  sub_32 u_sub (
    .a    (rem_sh),
    .b    (dsr_q),
    .diff (trial),
    .cout (no_borrow)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = b_zero ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == 5'd31) state_next = FIX;
      end
      FIX: begin
        busy = 1'b1;
        if (cnt != 5'd0) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = b_zero ? DONE : CALC;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (b_zero) begin
        quotient    <= DIV0_QUOTIENT;
        remainder   <= A;
        div_by_zero <= 1'b1;
      end else begin
        cnt   <= '0;
        rem_q <= '0;
        quo_q <= (is_signed && A[DIV_W-1]) ? twos_neg(A) : A;
        dsr_q <= (is_signed && B[DIV_W-1]) ? twos_neg(B) : B;
        neg_q <= is_signed && (A[DIV_W-1] ^ B[DIV_W-1]);
        neg_r <= is_signed && A[DIV_W-1];
      end
    end else if (state == CALC) begin
      rem_q <= take ? trial : rem_sh;
      quo_q <= {quo_q[DIV_W-2:0], take};
      cnt   <= cnt + 5'd1;
    end else if (state == FIX) begin
      if (cnt == 5'd0) begin
        quotient    <= neg_q ? twos_neg(quo_q) : quo_q;
        remainder   <= neg_r ? twos_neg(rem_q) : rem_q;
        div_by_zero <= 1'b0;
      end
      cnt <= cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_div_32_seq.sv
// Scoreboard bench for div_32_seq: expectations queued at issue, popped on done.
module tb_div_32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  div_32_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          busy_n;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent reference: SV arithmetic, with the two edge cases spelled out.
  function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                 input int t0);
    exp_t e;
    e.t0 = t0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 0; e.busy_n = 0;
    end else begin
      e.dz = 1'b0; e.lat = 34; e.busy_n = 34;
      if (!s) begin
        e.q = a / b; e.r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000; e.r = 32'h0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
    end
    return e;
  endfunction

  // Compare each done against the head of the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (busy) busy_cnt++;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quotient",    quotient,          e.q);
        check("remainder",   remainder,         e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        check("latency",     cyc - e.t0,        e.lat);
        check("busy_cycles", busy_cnt,          e.busy_n);
      end
      busy_cnt = 0;
    end
  end

  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; is_signed = s; A = a; B = b;
    sb.push_back(model(s, a, b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk); #1;
      seen = done;
      n++;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_q"},    quotient,  32'd0);
    check({tag, "_r"},    remainder, 32'd0);
    check({tag, "_dz"},   {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    bit          rs;

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue(1'b0, 32'd100, 32'd7);                     wait_drain(60);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);               wait_drain(60);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);       wait_drain(60);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1);               wait_drain(60);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);       wait_drain(60);
    issue(1'b0, 32'h1234_5678, 32'd0);               wait_drain(60);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE);               wait_drain(60);
    issue(1'b1, 32'hFFFF_FF9C, 32'd0);               wait_drain(60);
    issue(1'b0, 32'h8000_0001, 32'h8000_0000);       wait_drain(60);

    // Back-to-back: start in the DONE cycle is accepted.
    issue(1'b0, 32'd12345, 32'd100);
    wait_done(60);
    issue(1'b1, 32'hFFFF_FC18, 32'd33);
    wait_drain(60);

    // Reset during iterations aborts with no done.
    issue(1'b0, 32'd1000, 32'd10);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("mid_reset");
    sb.delete();
    busy_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    // A start during CALC is ignored; operands are not re-sampled.
    issue(1'b0, 32'd1000, 32'd10);
    repeat (5) @(negedge clk);
    start = 1'b1; is_signed = 1'b1; A = 32'd5; B = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_drain(60);

    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 7 == 0) rb = rb | 32'h8000_0000;
      issue(rs, ra, rb);
      wait_drain(60);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
